// File: rtl/iir_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// iir_cascade_sequencer : N_SEC biquad cascade sharing one multiplier/accumulator
// Revision 1.0
// ============================================================================
module iir_cascade_sequencer #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 14,
  parameter int N_SEC  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              clear_state,
  output logic              busy,
  output logic              sat_flag,
  output logic              cfg_err
);

  localparam int ACC_W = 2 * DATA_W + 8;
  localparam int SEC_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam logic signed [DATA_W-1:0] B0_UNITY = DATA_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0]  ROUND    = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  Y_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  Y_MIN    = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 mac_cnt_q;
  logic [SEC_W-1:0]           sec_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   x_q;
  logic signed [DATA_W-1:0]   x1_q [N_SEC];
  logic signed [DATA_W-1:0]   x2_q [N_SEC];
  logic signed [DATA_W-1:0]   y1_q [N_SEC];
  logic signed [DATA_W-1:0]   y2_q [N_SEC];
  logic signed [DATA_W-1:0]   coef_q [N_SEC][5];
  logic [DATA_W-1:0]          out_data_q;
  logic                       out_valid_q;
  logic                       sat_q;
  logic                       cfg_err_q;

  logic signed [DATA_W-1:0]   mul_c, mul_x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, acc_base, acc_d, rounded;
  logic signed [DATA_W-1:0]   y_sat;
  logic                       ovf;
  logic                       accept;
  logic                       cfg_ok;
  logic [SEC_W-1:0]           cfg_sec;

  assign in_ready  = (state_q == IDLE) && !out_valid_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;
  assign cfg_err   = cfg_err_q;
  assign accept    = in_valid && in_ready;

  assign cfg_sec = cfg_addr[3 +: SEC_W];
  assign cfg_ok  = (state_q == IDLE) && ({1'b0, cfg_addr[5:3]} < 4'(N_SEC)) &&
                   (cfg_addr[2:0] <= 3'd4);

  // Operand order per section: b0*x, b1*x1, b2*x2, a1*y1, a2*y2.
  always_comb begin
    mul_x = x_q;
    case (mac_cnt_q)
      3'd1:    mul_x = x1_q[sec_q];
      3'd2:    mul_x = x2_q[sec_q];
      3'd3:    mul_x = y1_q[sec_q];
      3'd4:    mul_x = y2_q[sec_q];
      default: mul_x = x_q;
    endcase
  end

  assign mul_c    = coef_q[sec_q][mac_cnt_q];
  assign prod     = mul_c * mul_x;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_base = (mac_cnt_q == 3'd0) ? '0 : acc_q;
  assign acc_d    = (mac_cnt_q >= 3'd3) ? acc_base - prod_ext : acc_base + prod_ext;
  assign rounded  = (acc_q + ROUND) >>> FRAC;

  always_comb begin
    y_sat = rounded[DATA_W-1:0];
    ovf   = 1'b0;
    if (rounded > Y_MAX) begin
      y_sat = Y_MAX[DATA_W-1:0];
      ovf   = 1'b1;
    end else if (rounded < Y_MIN) begin
      y_sat = Y_MIN[DATA_W-1:0];
      ovf   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (mac_cnt_q == 3'd4) state_d = WB;
      WB:      state_d = (sec_q == SEC_W'(N_SEC - 1)) ? OUT : MAC;
      OUT:     if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_cnt_q   <= '0;
      sec_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int s = 0; s < N_SEC; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
        for (int k = 0; k < 5; k++) coef_q[s][k] <= (k == 0) ? B0_UNITY : '0;
      end
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) coef_q[cfg_sec][cfg_addr[2:0]] <= cfg_wdata;

      case (state_q)
        IDLE: begin
          if (clear_state) begin
            for (int s = 0; s < N_SEC; s++) begin
              x1_q[s] <= '0;
              x2_q[s] <= '0;
              y1_q[s] <= '0;
              y2_q[s] <= '0;
            end
          end
          if (accept) begin
            x_q       <= in_data;
            sec_q     <= '0;
            mac_cnt_q <= '0;
            sat_q     <= 1'b0;
          end
        end
        MAC: begin
          acc_q     <= acc_d;
          mac_cnt_q <= (mac_cnt_q == 3'd4) ? 3'd0 : mac_cnt_q + 3'd1;
        end
        WB: begin
          // The section output becomes the next section's input sample.
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= y_sat;
          x_q         <= y_sat;
          sat_q       <= sat_q | ovf;
          sec_q       <= sec_q + 1'b1;
        end
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= x_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// tb_iir_cascade_sequencer : directed + randomized bench with arithmetic model
// Revision 1.0
// ============================================================================
module tb_iir_cascade_sequencer;

  localparam int DATA_W = 16;
  localparam int FRAC   = 14;
  localparam int N_SEC  = 5;
  localparam int LAT    = 6 * N_SEC + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              cfg_we = 1'b0;
  logic [5:0]        cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wdata = '0;
  logic              clear_state = 1'b0;
  logic              busy;
  logic              sat_flag;
  logic              cfg_err;

  int chk_cnt = 0;
  int err_cnt = 0;

  longint m_coef [N_SEC][5];
  longint m_x1 [N_SEC], m_x2 [N_SEC], m_y1 [N_SEC], m_y2 [N_SEC];

  iir_cascade_sequencer #(.DATA_W(DATA_W), .FRAC(FRAC), .N_SEC(N_SEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clear_state(clear_state), .busy(busy), .sat_flag(sat_flag), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset_lines();
    for (int s = 0; s < N_SEC; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endtask

  task automatic model_reset_all();
    model_reset_lines();
    for (int s = 0; s < N_SEC; s++)
      for (int k = 0; k < 5; k++) m_coef[s][k] = (k == 0) ? (64'sd1 <<< FRAC) : 0;
  endtask

  // Direct-form biquads in cascade, Q(FRAC) coefficients, round-half-up, saturate.
  task automatic model_step(input longint x, output longint y, output bit sat);
    longint xs, acc, r;
    xs  = x;
    sat = 1'b0;
    for (int s = 0; s < N_SEC; s++) begin
      acc = m_coef[s][0] * xs + m_coef[s][1] * m_x1[s] + m_coef[s][2] * m_x2[s]
          - m_coef[s][3] * m_y1[s] - m_coef[s][4] * m_y2[s];
      r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (r > 32767)       begin r = 32767;  sat = 1'b1; end
      else if (r < -32768) begin r = -32768; sat = 1'b1; end
      m_x2[s] = m_x1[s]; m_x1[s] = xs;
      m_y2[s] = m_y1[s]; m_y1[s] = r;
      xs = r;
    end
    y = xs;
  endtask

  task automatic cfg_write(input int sec, input int idx, input int val);
    cfg_we    = 1'b1;
    cfg_addr  = {3'(sec), 3'(idx)};
    cfg_wdata = DATA_W'(val);
    tick();
    cfg_we = 1'b0;
    check("cfg_err_on_valid_write", cfg_err, 0);
    m_coef[sec][idx] = val;
  endtask

  task automatic cfg_bad(input int sec, input int idx);
    cfg_we    = 1'b1;
    cfg_addr  = {3'(sec), 3'(idx)};
    cfg_wdata = 16'h1234;
    tick();
    cfg_we = 1'b0;
    check("cfg_err_pulse_idle", cfg_err, 1);
    tick();
    check("cfg_err_one_cycle", cfg_err, 0);
  endtask

  task automatic do_clear();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    model_reset_lines();
  endtask

  // mode 0: plain; 1: rejected cfg write while busy; 2: cfg write in the accepting cycle
  task automatic run_sample(input longint x, input int rdy_delay, input int mode,
                            output longint y);
    longint exp_y;
    bit     exp_sat;
    int     n;
    logic [DATA_W-1:0] held;
    if (mode == 2) m_coef[0][0] = 4096;
    model_step(x, exp_y, exp_sat);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(x);
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 16'd4096;
    end
    tick();
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = (rdy_delay == 0);
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 200) begin
      if (mode == 1 && n == 3) begin
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 16'd0;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      n++;
      if (mode == 1 && n == 4) check("cfg_err_busy_pulse", cfg_err, 1);
      if (mode == 1 && n == 5) check("cfg_err_busy_clear", cfg_err, 0);
    end
    cfg_we = 1'b0;
    check("out_valid_latency", n, LAT);
    check("out_data", longint'($signed(out_data)), exp_y);
    check("sat_flag", sat_flag, exp_sat);
    y    = longint'($signed(out_data));
    held = out_data;
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      check("bp_out_valid_held", out_valid, 1);
      check("bp_out_data_held", out_data, held);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("out_valid_after_handshake", out_valid, 0);
    check("idle_after_handshake", busy, 0);
    check("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    longint y;
    int     cnt;
    logic signed [15:0] r16;

    model_reset_all();

    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    run_sample(1000, 0, 0, y);
    check("default_passthrough", y, 1000);

    cfg_write(0, 0, 8192);
    do_clear();
    run_sample(1000, 0, 0, y);
    check("scale_half", y, 500);

    cfg_write(0, 0, 16384);
    cfg_write(0, 3, -8192);
    do_clear();
    run_sample(16384, 0, 0, y);
    check("fb_imp0", y, 16384);
    run_sample(0, 0, 0, y);
    check("fb_imp1", y, 8192);
    run_sample(0, 0, 0, y);
    check("fb_imp2", y, 4096);
    run_sample(0, 0, 0, y);
    check("fb_imp3", y, 2048);

    cfg_write(0, 3, 0);
    cfg_write(0, 0, 32767);
    do_clear();
    run_sample(32767, 0, 0, y);
    check("sat_out", y, 32767);
    check("sat_flag_set", sat_flag, 1);
    run_sample(0, 0, 0, y);
    check("sat_flag_cleared", sat_flag, 0);

    run_sample(1200, 10, 0, y);

    cfg_bad(N_SEC, 0);
    cfg_bad(0, 5);
    cfg_bad(7, 7);

    cfg_write(0, 0, 8192);
    do_clear();
    run_sample(1000, 0, 1, y);
    check("busy_cfg_ignored", y, 500);

    do_clear();
    run_sample(1000, 0, 2, y);
    check("same_cycle_cfg", y, 250);

    // Reset while the cascade is mid-sample.
    in_valid = 1'b1;
    in_data  = 16'd1000;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    model_reset_all();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("midrst_no_output", cnt, 0);
    run_sample(1000, 0, 0, y);
    check("midrst_coef_default", y, 1000);

    for (int s = 0; s < N_SEC; s++) begin
      cfg_write(s, 0, $urandom_range(32768) - 16384);
      cfg_write(s, 1, $urandom_range(32768) - 16384);
      cfg_write(s, 2, $urandom_range(16384) - 8192);
      cfg_write(s, 3, $urandom_range(16000) - 8000);
      cfg_write(s, 4, $urandom_range(8000) - 4000);
    end
    do_clear();
    for (int i = 0; i < 20; i++) begin
      r16 = 16'($urandom);
      run_sample(longint'(r16), $urandom_range(3), 0, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
